// File: rtl/othello_pkg.sv
// Shared definitions for the board datapath: cell codes, FSM states and
// the (row,col) -> padded memory address formula.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] CELL_WALL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_CHK,
    ST_WR,
    ST_DONE,
    ST_REJ
  } state_t;

  // The wall ring shifts every playable coordinate by one in both axes.
  function automatic int unsigned pad_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned board_n);
    return (row + 1) * (board_n + 2) + col + 1;
  endfunction

endpackage

// File: rtl/board_addr_map.sv
// Combinational switch-coordinate to padded-address map with range check.
module board_addr_map
  import othello_pkg::*;
#(
  parameter int unsigned BOARD_N = 8,
  parameter int unsigned COORD_W = 3,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic [2*COORD_W-1:0] coord,
  output logic [ADDR_W-1:0]    addr,
  output logic                 in_range
);

  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;

  always_comb begin
    row      = coord[2*COORD_W-1:COORD_W];
    col      = coord[COORD_W-1:0];
    in_range = (32'(row) < BOARD_N) && (32'(col) < BOARD_N);
    addr     = ADDR_W'(pad_addr(32'(row), 32'(col), BOARD_N));
  end

endmodule

// File: rtl/move_commit_unit.sv
// Board move/flip commit FSM between the control FSM and the single-port
// board RAM; also tracks piece count, consecutive passes and game end.
module move_commit_unit
  import othello_pkg::*;
#(
  parameter int unsigned BOARD_N = 8,
  parameter int unsigned COORD_W = 3,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned CNT_W   = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2*COORD_W-1:0] e_addr_in,
  input  logic [ADDR_W-1:0]    i_addr_in,
  input  logic                 ld_e_addr,
  input  logic                 ld_i_addr,
  input  logic                 player,
  input  logic                 pass,
  input  logic [1:0]           mem_rdata,
  output logic [ADDR_W-1:0]    addr_to_mem,
  output logic [1:0]           data_to_mem,
  output logic                 wren,
  output logic                 rden,
  output logic                 busy,
  output logic                 ack,
  output logic                 nack,
  output logic [ADDR_W-1:0]    s_addr_out,
  output logic [CNT_W-1:0]     piece_cnt,
  output logic                 game_end
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(BOARD_N * BOARD_N);
  localparam int unsigned       WAIT_W    = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 2);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          colour_q;
  logic                ext_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [1:0]          pass_cnt;

  logic [ADDR_W-1:0]   e_addr;
  logic                e_in_range;
  logic                accept_i;
  logic                accept_e;
  logic                accept_p;
  logic                commit_e;
  logic [CNT_W-1:0]    cnt_inc;
  logic                end_hit;

  board_addr_map #(
    .BOARD_N (BOARD_N),
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W)
  ) u_map (
    .coord    (e_addr_in),
    .addr     (e_addr),
    .in_range (e_in_range)
  );

  // Flips outrank moves; once the game is over only moves get a response (nack).
  always_comb begin
    accept_i = (state == ST_IDLE) && ld_i_addr && !game_end;
    accept_e = (state == ST_IDLE) && !accept_i && ld_e_addr;
    accept_p = (state == ST_IDLE) && !ld_i_addr && !ld_e_addr && pass && !game_end;
    commit_e = (state == ST_WR) && ext_q;
    cnt_inc  = (piece_cnt == CNT_MAX) ? piece_cnt : piece_cnt + CNT_W'(1);
    end_hit  = (commit_e && (cnt_inc == CNT_MAX)) || (accept_p && (pass_cnt == 2'd1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept_i)      state_nxt = ST_WR;
        else if (accept_e) state_nxt = (game_end || !e_in_range) ? ST_REJ : ST_RD;
      end
      ST_RD:   state_nxt = (RD_LAT > 1) ? ST_WAIT : ST_CHK;
      ST_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = ST_CHK;
      ST_CHK:  state_nxt = (mem_rdata == CELL_EMPTY) ? ST_WR : ST_REJ;
      ST_WR:   state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      ST_REJ:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    rden        = (state == ST_RD);
    wren        = (state == ST_WR);
    ack         = (state == ST_DONE);
    nack        = (state == ST_REJ);
    addr_to_mem = (state inside {ST_RD, ST_WAIT, ST_CHK, ST_WR}) ? addr_q : '0;
    data_to_mem = wren ? colour_q : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      colour_q   <= '0;
      ext_q      <= 1'b0;
      wait_cnt   <= '0;
      pass_cnt   <= '0;
      piece_cnt  <= '0;
      s_addr_out <= '0;
      game_end   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      if (accept_i) begin
        addr_q   <= i_addr_in;
        colour_q <= player ? CELL_WHITE : CELL_BLACK;
        ext_q    <= 1'b0;
      end else if (accept_e) begin
        addr_q   <= e_addr;
        colour_q <= player ? CELL_WHITE : CELL_BLACK;
        ext_q    <= 1'b1;
      end
      if (commit_e) begin
        piece_cnt  <= cnt_inc;
        s_addr_out <= addr_q;
        pass_cnt   <= '0;
      end else if (accept_p) begin
        pass_cnt <= pass_cnt + 2'd1;
      end
      if (end_hit) game_end <= 1'b1;
    end
  end

endmodule

// File: tb/tb_move_commit_unit.sv
// Bench for move_commit_unit: default-parameter DUT against a board/score model,
// plus a BOARD_N=6, RD_LAT=3 instance for latency and range boundaries.
`timescale 1ns/1ps
module tb_move_commit_unit;

  localparam int RA = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [5:0] a_e = '0;
  logic [6:0] a_i = '0;
  logic a_ld_e = 0, a_ld_i = 0, a_player = 0, a_pass = 0;
  logic [1:0] a_rdata, a_data;
  logic [6:0] a_addr, a_saddr, a_cnt;
  logic a_wren, a_rden, a_busy, a_ack, a_nack, a_end;

  logic [5:0] b_e = '0;
  logic [6:0] b_i = '0;
  logic b_ld_e = 0, b_ld_i = 0, b_player = 0, b_pass = 0;
  logic [1:0] b_rdata, b_data;
  logic [6:0] b_addr, b_saddr, b_cnt;
  logic b_wren, b_rden, b_busy, b_ack, b_nack, b_end;

  move_commit_unit u_dut_a (
    .clock(clock), .reset(reset), .e_addr_in(a_e), .i_addr_in(a_i),
    .ld_e_addr(a_ld_e), .ld_i_addr(a_ld_i), .player(a_player), .pass(a_pass),
    .mem_rdata(a_rdata), .addr_to_mem(a_addr), .data_to_mem(a_data),
    .wren(a_wren), .rden(a_rden), .busy(a_busy), .ack(a_ack), .nack(a_nack),
    .s_addr_out(a_saddr), .piece_cnt(a_cnt), .game_end(a_end)
  );

  move_commit_unit #(
    .BOARD_N(6), .COORD_W(3), .ADDR_W(7), .RD_LAT(3), .CNT_W(7)
  ) u_dut_b (
    .clock(clock), .reset(reset), .e_addr_in(b_e), .i_addr_in(b_i),
    .ld_e_addr(b_ld_e), .ld_i_addr(b_ld_i), .player(b_player), .pass(b_pass),
    .mem_rdata(b_rdata), .addr_to_mem(b_addr), .data_to_mem(b_data),
    .wren(b_wren), .rden(b_rden), .busy(b_busy), .ack(b_ack), .nack(b_nack),
    .s_addr_out(b_saddr), .piece_cnt(b_cnt), .game_end(b_end)
  );

  // Board RAM models; non-read cycles return the wall code so mistimed sampling shows up.
  logic [1:0] ram_a [128];
  logic [1:0] ram_b [128];
  logic [1:0] pipe_b [3];
  logic ram_clr = 0, pre_en = 0;
  logic [6:0] pre_addr = '0;
  logic [1:0] pre_data = '0;

  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 128; i++) begin
        ram_a[i] <= 2'b00;
        ram_b[i] <= 2'b00;
      end
    end else begin
      if (pre_en) ram_a[pre_addr] <= pre_data;
      if (a_wren) ram_a[a_addr] <= a_data;
      if (b_wren) ram_b[b_addr] <= b_data;
    end
    a_rdata   <= a_rden ? ram_a[a_addr] : 2'b11;
    pipe_b[0] <= b_rden ? ram_b[b_addr] : 2'b11;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_rdata = pipe_b[2];

  // Reference model of the game state seen through DUT A.
  logic [1:0] m_board [128];
  int m_pieces, m_last, m_passes;
  bit m_end;
  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    for (int i = 0; i < 128; i++) m_board[i] = 2'b00;
    m_pieces = 0; m_last = 0; m_passes = 0; m_end = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 0; ram_clr = 1;
    a_ld_e = 0; a_ld_i = 0; a_pass = 0; b_ld_e = 0;
    model_clear();
    @(negedge clock);
    @(negedge clock);
    ram_clr = 0; reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 0; ram_clr = 1;
    model_clear();
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({a_wren, a_rden, a_busy, a_ack, a_nack, a_end} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl_a got=%b exp=000000", {a_wren, a_rden, a_busy, a_ack, a_nack, a_end});
    end
    checks++;
    if ({a_addr, a_data, a_saddr, a_cnt} !== 23'b0) begin
      errors++; $display("FAIL reset_data_a got=%h exp=0", {a_addr, a_data, a_saddr, a_cnt});
    end
    checks++;
    if ({b_wren, b_rden, b_busy, b_ack, b_nack, b_end, b_cnt, b_saddr} !== 20'b0) begin
      errors++; $display("FAIL reset_b got=%h exp=0", {b_wren, b_rden, b_busy, b_ack, b_nack, b_end, b_cnt, b_saddr});
    end
    ram_clr = 0; reset = 1;
    @(negedge clock);
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", a_busy); end
  endtask

  task automatic run_move(input int row, input int col, input bit pl);
    int addr, e_rd, e_wr, e_ack, e_nack;
    int g_rd, g_wr, g_ack, g_nack, n_rd, n_wr, n_ack, n_nack;
    bit both, commit;
    logic [6:0] r_addr, w_addr;
    logic [1:0] w_data, code;
    g_rd = -1; g_wr = -1; g_ack = -1; g_nack = -1;
    n_rd = 0; n_wr = 0; n_ack = 0; n_nack = 0; both = 0; commit = 0;
    r_addr = '0; w_addr = '0; w_data = '0;
    addr = (row + 1) * 10 + col + 1;
    code = pl ? 2'b10 : 2'b01;
    e_rd = -1; e_wr = -1; e_ack = -1; e_nack = -1;
    if (m_end || row >= 8 || col >= 8) e_nack = 1;
    else begin
      e_rd = 1;
      if (m_board[addr] != 2'b00) e_nack = 2 + RA;
      else begin commit = 1; e_wr = 2 + RA; e_ack = 3 + RA; end
    end
    @(negedge clock);
    a_e = {3'(row), 3'(col)}; a_ld_e = 1; a_player = pl;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      a_ld_e = 0; a_player = 1'($urandom_range(0, 1)); a_e = 6'($urandom);
      if (a_rden) begin n_rd++; if (g_rd < 0) begin g_rd = k; r_addr = a_addr; end end
      if (a_wren) begin n_wr++; if (g_wr < 0) begin g_wr = k; w_addr = a_addr; w_data = a_data; end end
      if (a_ack) begin n_ack++; if (g_ack < 0) g_ack = k; end
      if (a_nack) begin n_nack++; if (g_nack < 0) g_nack = k; end
      if (a_ack && a_nack) both = 1;
    end
    if (commit) begin
      m_board[addr] = code;
      if (m_pieces < 64) m_pieces++;
      m_last = addr; m_passes = 0;
      if (m_pieces == 64) m_end = 1;
    end
    checks++; if (g_rd != e_rd) begin errors++; $display("FAIL move_rden_cycle (%0d,%0d) got=%0d exp=%0d", row, col, g_rd, e_rd); end
    checks++; if (n_rd != (e_rd > 0 ? 1 : 0)) begin errors++; $display("FAIL move_rden_count got=%0d exp=%0d", n_rd, (e_rd > 0 ? 1 : 0)); end
    if (e_rd > 0) begin
      checks++; if (r_addr !== 7'(addr)) begin errors++; $display("FAIL move_rd_addr got=%0d exp=%0d", r_addr, addr); end
    end
    checks++; if (g_wr != e_wr) begin errors++; $display("FAIL move_wren_cycle got=%0d exp=%0d", g_wr, e_wr); end
    checks++; if (n_wr != (commit ? 1 : 0)) begin errors++; $display("FAIL move_wren_count got=%0d exp=%0d", n_wr, (commit ? 1 : 0)); end
    if (commit) begin
      checks++; if (w_addr !== 7'(addr)) begin errors++; $display("FAIL move_wr_addr got=%0d exp=%0d", w_addr, addr); end
      checks++; if (w_data !== code) begin errors++; $display("FAIL move_wr_data got=%b exp=%b", w_data, code); end
    end
    checks++; if (g_ack != e_ack || n_ack != (commit ? 1 : 0)) begin errors++; $display("FAIL move_ack got=%0d/%0d exp=%0d", g_ack, n_ack, e_ack); end
    checks++; if (g_nack != e_nack || n_nack != (commit ? 0 : 1)) begin errors++; $display("FAIL move_nack got=%0d/%0d exp=%0d", g_nack, n_nack, e_nack); end
    checks++; if (both) begin errors++; $display("FAIL ack_nack_overlap got=1 exp=0"); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL move_idle_busy got=%b exp=0", a_busy); end
    checks++; if (a_cnt !== 7'(m_pieces)) begin errors++; $display("FAIL move_piece_cnt got=%0d exp=%0d", a_cnt, m_pieces); end
    checks++; if (a_saddr !== 7'(m_last)) begin errors++; $display("FAIL move_s_addr got=%0d exp=%0d", a_saddr, m_last); end
    checks++; if (a_end !== m_end) begin errors++; $display("FAIL move_game_end got=%b exp=%b", a_end, m_end); end
  endtask

  task automatic run_flip(input int addr, input bit pl, input bit with_e);
    int e_wr, e_ack, e_busy, g_wr, g_ack, n_wr, n_ack, n_rd, n_nack, n_busy;
    logic [6:0] w_addr;
    logic [1:0] w_data, code;
    code = pl ? 2'b10 : 2'b01;
    e_wr = m_end ? -1 : 1; e_ack = m_end ? -1 : 2; e_busy = m_end ? 0 : 2;
    g_wr = -1; g_ack = -1; n_wr = 0; n_ack = 0; n_rd = 0; n_nack = 0; n_busy = 0;
    w_addr = '0; w_data = '0;
    @(negedge clock);
    a_i = 7'(addr); a_ld_i = 1; a_player = pl;
    if (with_e) begin a_ld_e = 1; a_e = 6'($urandom); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      a_ld_i = 0; a_ld_e = 0; a_player = ~pl; a_i = 7'($urandom);
      if (a_busy) n_busy++;
      if (a_rden) n_rd++;
      if (a_nack) n_nack++;
      if (a_wren) begin n_wr++; if (g_wr < 0) begin g_wr = k; w_addr = a_addr; w_data = a_data; end end
      if (a_ack) begin n_ack++; if (g_ack < 0) g_ack = k; end
    end
    if (!m_end) m_board[addr] = code;
    checks++; if (g_wr != e_wr || n_wr != (m_end ? 0 : 1)) begin errors++; $display("FAIL flip_wren got=%0d/%0d exp=%0d", g_wr, n_wr, e_wr); end
    if (e_wr > 0) begin
      checks++; if (w_addr !== 7'(addr) || w_data !== code) begin errors++; $display("FAIL flip_write got=%0d:%b exp=%0d:%b", w_addr, w_data, addr, code); end
    end
    checks++; if (g_ack != e_ack || n_ack != (m_end ? 0 : 1)) begin errors++; $display("FAIL flip_ack got=%0d/%0d exp=%0d", g_ack, n_ack, e_ack); end
    checks++; if (n_rd != 0 || n_nack != 0) begin errors++; $display("FAIL flip_no_read got=rd%0d nack%0d exp=0", n_rd, n_nack); end
    checks++; if (n_busy != e_busy) begin errors++; $display("FAIL flip_busy got=%0d exp=%0d", n_busy, e_busy); end
    checks++; if (a_cnt !== 7'(m_pieces) || a_saddr !== 7'(m_last)) begin errors++; $display("FAIL flip_counters got=%0d/%0d exp=%0d/%0d", a_cnt, a_saddr, m_pieces, m_last); end
  endtask

  task automatic run_pass();
    int n_busy, n_resp;
    n_busy = 0; n_resp = 0;
    @(negedge clock);
    a_pass = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      a_pass = 0;
      if (a_busy) n_busy++;
      if (a_ack || a_nack) n_resp++;
    end
    if (!m_end) begin m_passes++; if (m_passes >= 2) m_end = 1; end
    checks++; if (n_busy != 0 || n_resp != 0) begin errors++; $display("FAIL pass_quiet got=busy%0d resp%0d exp=0", n_busy, n_resp); end
    checks++; if (a_end !== m_end) begin errors++; $display("FAIL pass_game_end got=%b exp=%b", a_end, m_end); end
  endtask

  function automatic int rand_cell();
    return (int'($urandom_range(0, 7)) + 1) * 10 + int'($urandom_range(0, 7)) + 1;
  endfunction

  task automatic test_place_basic();
    run_move(3, 4, 0);
    checks++; if (a_saddr !== 7'd45 || a_cnt !== 7'd1) begin errors++; $display("FAIL basic_place got=%0d/%0d exp=45/1", a_saddr, a_cnt); end
  endtask

  task automatic test_occupied();
    @(negedge clock);
    pre_en = 1; pre_addr = 7'd45; pre_data = 2'b10;
    @(negedge clock);
    pre_en = 0;
    m_board[45] = 2'b10;
    run_move(3, 4, 0);
  endtask

  task automatic test_flip_priority();
    run_flip(23, 1, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (m_end && $urandom_range(0, 3) == 0) do_reset();
      if (op < 12) run_move(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else if (op < 18) run_flip(rand_cell(), 1'($urandom_range(0, 1)), m_end ? 1'b0 : 1'($urandom_range(0, 1)));
      else run_pass();
    end
  endtask

  task automatic test_fill();
    int order[64];
    do_reset();
    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int j = 0; j < 64; j++) begin
      run_move(order[j] / 8, order[j] % 8, 1'($urandom_range(0, 1)));
      if (j % 8 == 3) run_move(order[j - 1] / 8, order[j - 1] % 8, 1'($urandom_range(0, 1)));
      if (j % 8 == 6) run_flip((order[j] / 8 + 1) * 10 + order[j] % 8 + 1, 1'($urandom_range(0, 1)), 0);
      if (j % 16 == 5) run_pass();
    end
    checks++; if (a_end !== 1'b1 || a_cnt !== 7'd64) begin errors++; $display("FAIL fill_game_end got=%b/%0d exp=1/64", a_end, a_cnt); end
    run_move(0, 0, 0);
    run_flip(11, 1, 0);
  endtask

  task automatic test_pass();
    do_reset();
    run_move(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1);
    run_pass();
    run_flip(rand_cell(), 0, 0);
    run_pass();
    checks++; if (a_end !== 1'b1) begin errors++; $display("FAIL two_pass_end got=%b exp=1", a_end); end
    run_move(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0);
    run_flip(rand_cell(), 1, 0);
    run_pass();
  endtask

  task automatic b_move(input int row, input int col, input bit pl, input int e_rd, input int e_wr,
                        input int e_ack, input int e_nack, input int e_addr, input string tag);
    int g_rd, g_wr, g_ack, g_nack, n_ev;
    logic [6:0] r_addr, w_addr;
    logic [1:0] w_data;
    g_rd = -1; g_wr = -1; g_ack = -1; g_nack = -1; n_ev = 0;
    r_addr = '0; w_addr = '0; w_data = '0;
    @(negedge clock);
    b_e = {3'(row), 3'(col)}; b_ld_e = 1; b_player = pl;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      b_ld_e = 0; b_player = ~pl;
      if (b_rden || b_wren || b_ack || b_nack) n_ev++;
      if (b_rden && g_rd < 0) begin g_rd = k; r_addr = b_addr; end
      if (b_wren && g_wr < 0) begin g_wr = k; w_addr = b_addr; w_data = b_data; end
      if (b_ack && g_ack < 0) g_ack = k;
      if (b_nack && g_nack < 0) g_nack = k;
    end
    checks++; if (g_rd != e_rd || g_wr != e_wr) begin errors++; $display("FAIL %s_mem_cycles got=rd%0d wr%0d exp=rd%0d wr%0d", tag, g_rd, g_wr, e_rd, e_wr); end
    checks++; if (g_ack != e_ack || g_nack != e_nack) begin errors++; $display("FAIL %s_resp got=ack%0d nack%0d exp=ack%0d nack%0d", tag, g_ack, g_nack, e_ack, e_nack); end
    checks++; if (n_ev != (e_rd > 0 ? 1 : 0) + (e_wr > 0 ? 1 : 0) + 1) begin errors++; $display("FAIL %s_event_count got=%0d", tag, n_ev); end
    if (e_rd > 0) begin
      checks++; if (r_addr !== 7'(e_addr)) begin errors++; $display("FAIL %s_rd_addr got=%0d exp=%0d", tag, r_addr, e_addr); end
    end
    if (e_wr > 0) begin
      checks++; if (w_addr !== 7'(e_addr) || w_data !== (pl ? 2'b10 : 2'b01)) begin errors++; $display("FAIL %s_write got=%0d:%b exp=%0d:%b", tag, w_addr, w_data, e_addr, (pl ? 2'b10 : 2'b01)); end
    end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL %s_idle got=%b exp=0", tag, b_busy); end
  endtask

  task automatic test_rd_latency3();
    do_reset();
    b_move(6, 0, 0, -1, -1, -1, 1, 0, "lat3_row6");
    b_move(2, 7, 0, -1, -1, -1, 1, 0, "lat3_col7");
    b_move(0, 0, 1, 1, 5, 6, -1, 9, "lat3_origin");
    b_move(5, 5, 0, 1, 5, 6, -1, 54, "lat3_corner");
    b_move(0, 0, 0, 1, -1, -1, 5, 9, "lat3_occupied");
    checks++; if (b_cnt !== 7'd2 || b_saddr !== 7'd54) begin errors++; $display("FAIL lat3_counters got=%0d/%0d exp=2/54", b_cnt, b_saddr); end
  endtask

  task automatic test_reset_mid_wr();
    do_reset();
    run_move(2, 2, 0);
    @(negedge clock);
    a_e = {3'd4, 3'd4}; a_ld_e = 1; a_player = 1;
    for (int k = 1; k <= 2 + RA; k++) begin
      @(negedge clock);
      a_ld_e = 0;
    end
    checks++; if (a_wren !== 1'b1) begin errors++; $display("FAIL midwr_precond got=%b exp=1", a_wren); end
    reset = 0;
    @(negedge clock);
    checks++; if (a_wren !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL midwr_ctl got=%b%b exp=00", a_wren, a_busy); end
    checks++; if (a_cnt !== 7'd0 || a_end !== 1'b0 || a_ack !== 1'b0) begin errors++; $display("FAIL midwr_state got=%0d/%b/%b exp=0/0/0", a_cnt, a_end, a_ack); end
    reset = 1;
    model_clear();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_place_basic();
    test_occupied();
    test_flip_priority();
    test_random();
    test_fill();
    test_pass();
    test_rd_latency3();
    test_reset_mid_wr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
